// File: rtl/video_pattern_tx_if.sv
// rtl/video_pattern_tx_if.sv - video output bundle: syncs, data enable, pixel position and 3-bit RGB
interface video_pattern_tx_if;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [10:0] col;
    logic [9:0]  row;
    logic [2:0]  rgb;

    modport master (output hsync, vsync, de, col, row, rgb);
    modport slave  (input  hsync, vsync, de, col, row, rgb);
endinterface

// File: rtl/video_pattern_tx.sv
// rtl/video_pattern_tx.sv - 800x600@72 timing generator with 3-bit RGB test patterns; VIDEO_PATTERN_SCROLL_EN scrolls the bars
module video_pattern_tx #(
    parameter int   H_VISIBLE = 800,
    parameter int   H_FRONT   = 56,
    parameter int   H_SYNC    = 120,
    parameter int   H_BACK    = 64,
    parameter int   V_VISIBLE = 600,
    parameter int   V_FRONT   = 37,
    parameter int   V_SYNC    = 6,
    parameter int   V_BACK    = 23,
    parameter logic HS_POL    = 1'b1,
    parameter logic VS_POL    = 1'b1,
    parameter int   BAR_W     = 100
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [1:0]                 pattern_sel,
    input  logic [2:0]                 solid_rgb,
    video_pattern_tx_if.master         video,
    output logic [7:0]                 frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] COL_LAST = 11'(H_VISIBLE - 1);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0]  ROW_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        frame_start;
    logic        line_end;
    logic        frame_end;
    logic        visible;
    logic        hs_win;
    logic        vs_win;

    logic [1:0]  pat_q;
    logic [2:0]  solid_q;
    logic [1:0]  pat_cur;
    logic [2:0]  solid_cur;

    logic [10:0] bar_pix_q;
    logic [2:0]  bar_idx_q;
    logic [10:0] bar_pix_cur;
    logic [2:0]  bar_idx_cur;
    logic [10:0] start_pix;
    logic [2:0]  start_idx;
    logic [13:0] bar_nxt;
    logic [2:0]  pix_rgb;

    // One pixel step of the bar counter: {pixel-within-bar, bar index}, index saturating at 7.
    function automatic logic [13:0] bar_step(input logic [10:0] pix, input logic [2:0] idx);
        if (pix == BAR_LAST) begin
            return {11'd0, (idx == 3'd7) ? idx : idx + 3'd1};
        end
        return {pix + 11'd1, idx};
    endfunction

    assign frame_start = (h_cnt == 11'd0) && (v_cnt == 10'd0);
    assign line_end    = (h_cnt == H_LAST);
    assign frame_end   = line_end && (v_cnt == V_LAST);
    assign visible     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_win      = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_win      = (v_cnt >= VS_START) && (v_cnt < VS_END);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    // The first pixel of a frame uses the inputs directly so a new selection applies from (0,0).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pat_q   <= '0;
            solid_q <= '0;
        end else if (enable && frame_start) begin
            pat_q   <= pattern_sel;
            solid_q <= solid_rgb;
        end
    end

    assign pat_cur   = frame_start ? pattern_sel : pat_q;
    assign solid_cur = frame_start ? solid_rgb : solid_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
        end else if (enable && frame_end) begin
            frame_count <= frame_count + 8'd1;
        end
    end

`ifdef VIDEO_PATTERN_SCROLL_EN
    logic [10:0] offset_q;
    logic [10:0] off_pix_q;
    logic [2:0]  off_idx_q;
    logic [10:0] pos_q;
    logic [10:0] pos_cur;

    // off_pix/off_idx track the bar position of the offset itself, so each line can start without a divider.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            offset_q  <= '0;
            off_pix_q <= '0;
            off_idx_q <= '0;
        end else if (enable && frame_end) begin
            if (offset_q == COL_LAST) begin
                offset_q  <= '0;
                off_pix_q <= '0;
                off_idx_q <= '0;
            end else begin
                offset_q               <= offset_q + 11'd1;
                {off_pix_q, off_idx_q} <= bar_step(off_pix_q, off_idx_q);
            end
        end
    end

    assign start_pix = off_pix_q;
    assign start_idx = off_idx_q;
    assign pos_cur   = (h_cnt == 11'd0) ? offset_q : pos_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos_q <= '0;
        end else if (!enable) begin
            pos_q <= '0;
        end else begin
            pos_q <= (pos_cur == COL_LAST) ? 11'd0 : pos_cur + 11'd1;
        end
    end
`else
    assign start_pix = '0;
    assign start_idx = '0;
`endif

    always_comb begin
        bar_pix_cur = (h_cnt == 11'd0) ? start_pix : bar_pix_q;
        bar_idx_cur = (h_cnt == 11'd0) ? start_idx : bar_idx_q;
        bar_nxt     = bar_step(bar_pix_cur, bar_idx_cur);
`ifdef VIDEO_PATTERN_SCROLL_EN
        if (pos_cur == COL_LAST) begin
            bar_nxt = '0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bar_pix_q <= '0;
            bar_idx_q <= '0;
        end else if (!enable) begin
            bar_pix_q <= '0;
            bar_idx_q <= '0;
        end else begin
            {bar_pix_q, bar_idx_q} <= bar_nxt;
        end
    end

    always_comb begin
        pix_rgb = 3'b000;
        case (pat_cur)
            2'b00:   pix_rgb = bar_idx_cur;
            2'b01:   pix_rgb = {3{h_cnt[3] ^ v_cnt[3]}};
            2'b10:   pix_rgb = (h_cnt == 11'd0 || h_cnt == COL_LAST ||
                                v_cnt == 10'd0 || v_cnt == ROW_LAST) ? 3'b111 : 3'b000;
            default: pix_rgb = solid_cur;
        endcase
    end

    // All video outputs are registered together so they stay aligned one cycle behind the counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            video.hsync <= ~HS_POL;
            video.vsync <= ~VS_POL;
            video.de    <= 1'b0;
            video.col   <= '0;
            video.row   <= '0;
            video.rgb   <= '0;
        end else if (!enable) begin
            video.hsync <= ~HS_POL;
            video.vsync <= ~VS_POL;
            video.de    <= 1'b0;
            video.rgb   <= '0;
        end else begin
            video.hsync <= hs_win ? HS_POL : ~HS_POL;
            video.vsync <= vs_win ? VS_POL : ~VS_POL;
            video.de    <= visible;
            video.rgb   <= visible ? pix_rgb : 3'b000;
            if (visible) begin
                video.col <= h_cnt;
                video.row <= v_cnt;
            end
        end
    end

endmodule
